window_framer: RTL

//   Upstream neighbour of the windowing stage. Collects a stream of WIDTH-bit

---
 rtl/window_framer_if.sv | 25 ++
 rtl/window_framer.sv | 109 ++++++++++
 2 files changed

// File: rtl/window_framer_if.sv
// Sample-in / frame-out handshake bundle for the window framer.
// The master side is the environment; the slave side is the framer.
interface window_framer_if #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned WIDTH = 8
);
  logic                    flush;
  logic [WIDTH-1:0]        in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [SIZE*WIDTH-1:0]   frame_data;
  logic                    frame_valid;
  logic                    frame_ready;
  logic [7:0]              frame_idx;

  modport master (
    output flush, in_data, in_valid, frame_ready,
    input  in_ready, frame_data, frame_valid, frame_idx
  );

  modport slave (
    input  flush, in_data, in_valid, frame_ready,
    output in_ready, frame_data, frame_valid, frame_idx
  );
endinterface

// File: rtl/window_framer.sv
// Collects WIDTH-bit samples into SIZE-sample frames with a HOP-sample stride,
// presenting each frame as one packed bus behind a valid/ready handshake.
module window_framer #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned HOP   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  window_framer_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(SIZE);
  localparam int unsigned DATA_W = SIZE * WIDTH;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_EMIT = 2'd1,
    ST_HOP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   shreg_q;
  logic                valid_q;
  logic                ready_q;
  logic                accept_c;
  logic                clear_c;

  // Next-state decode; flush overrides every other transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    accept_c = 1'b0;
    clear_c  = 1'b0;
    if (bus.flush) begin
      state_d = ST_FILL;
      cnt_d   = '0;
      clear_c = 1'b1;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (bus.in_valid) begin
            accept_c = 1'b1;
            if (cnt_q == CNT_W'(SIZE - 1)) begin
              state_d = ST_EMIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (bus.frame_ready) begin
            state_d = ST_HOP;
            cnt_d   = '0;
            idx_d   = idx_q + 8'd1;
          end
        end
        ST_HOP: begin
          if (bus.in_valid) begin
            accept_c = 1'b1;
            if (cnt_q == CNT_W'(HOP - 1)) begin
              state_d = ST_EMIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      valid_q <= (state_d == ST_EMIT);
      ready_q <= (state_d != ST_EMIT);
      if (clear_c) begin
        shreg_q <= '0;
      end else if (accept_c) begin
        shreg_q <= {bus.in_data, shreg_q[DATA_W-1:WIDTH]};
      end
    end
  end

  assign bus.in_ready    = ready_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_data  = shreg_q;
  assign bus.frame_idx   = idx_q;

endmodule
